// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM read arbiter.
// Requester 0 is the video line fetch; all others are general readers.
package sram_pkg;

    localparam int NREQ     = 4;
    localparam int READ_LAT = 2;
    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 16;
    localparam int LEN_W    = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Index width for a requester number; never zero even with one requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: returns the first active request at or after i_ptr
// (wrapping), as a one-hot vector.
module rr_picker
    import sram_pkg::*;
#(
    parameter int NREQ  = sram_pkg::NREQ,
    parameter int IDX_W = idx_w(sram_pkg::NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDX_W'((int'(i_ptr) + i) % NREQ);
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin read arbiter for an asynchronous SRAM: grants one burst at a
// time, issues len+1 sequential addresses and returns tagged read data.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int NREQ     = sram_pkg::NREQ,
    parameter int READ_LAT = sram_pkg::READ_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*ADDR_W-1:0] i_addr,
    input  logic [NREQ*LEN_W-1:0]  i_len,
    output logic [NREQ-1:0]        o_gnt,
    output logic [NREQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]      o_rdata,
    output logic [ADDR_W-1:0]      o_sram_addr,
    input  logic [DATA_W-1:0]      i_sram_dq,
    output logic                   o_sram_ce_n,
    output logic                   o_sram_oe_n,
    output logic                   o_sram_we_n,
    output logic                   o_busy
);

    localparam int IDX_W = idx_w(NREQ);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    owner_q, owner_d;

    logic                issuing;
    logic                last_beat;
    logic                arb_en;
    logic                any_gnt;
    logic [NREQ-1:0]     pick;
    logic [NREQ-1:0]     gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [LEN_W-1:0]    gnt_len;

    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [IDX_W-1:0]    own_q [READ_LAT];
    logic [IDX_W-1:0]    own_d [READ_LAT];
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sample;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_req (i_req),
        .i_ptr (ptr_q),
        .o_gnt (pick)
    );

    // Arbitration window and the granted requester's burst parameters.
    always_comb begin
        issuing   = (state_q == S_ISSUE);
        last_beat = issuing && (cnt_q == '0);
        arb_en    = (state_q == S_IDLE) || last_beat;
        gnt       = arb_en ? pick : '0;
        any_gnt   = |gnt;
        gnt_idx   = '0;
        gnt_addr  = '0;
        gnt_len   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_idx  = IDX_W'(k);
                gnt_addr = i_addr[k*ADDR_W +: ADDR_W];
                gnt_len  = i_len[k*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;

        case (state_q)
            S_IDLE: begin
                if (any_gnt) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_beat) begin
                    if (!any_gnt) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A grant always reloads the burst, whether from idle or back-to-back.
        if (any_gnt) begin
            addr_d  = gnt_addr;
            cnt_d   = gnt_len;
            owner_d = gnt_idx;
            ptr_d   = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Read-return pipeline tracks issued beats independently of the FSM.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issuing;
        own_d[0] = owner_q;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
        rdata_d = sample ? i_sram_dq : rdata_q;
    end

    generate
        if (READ_LAT == 1) begin : g_sample_lat1
            assign sample = issuing;
        end else begin : g_sample_latn
            assign sample = vld_q[READ_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            vld_q   <= '0;
            rdata_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                own_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
            own_q   <= own_d;
        end
    end

    always_comb begin
        o_rvalid = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (vld_q[READ_LAT-1] && (own_q[READ_LAT-1] == IDX_W'(k))) begin
                o_rvalid[k] = 1'b1;
            end
        end
    end

    // Grant is combinational from i_req, so it is masked while reset is held.
    assign o_gnt       = gnt & {NREQ{rst_n}};
    assign o_rdata     = rdata_q;
    assign o_sram_addr = addr_q;
    assign o_sram_ce_n = ~issuing;
    assign o_sram_oe_n = ~issuing;
    assign o_sram_we_n = 1'b1;
    assign o_busy      = issuing;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table plus hand-written
// sequences for long bursts, withdrawn requests and mid-burst reset.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_req = '0;
    logic [79:0] i_addr;
    logic [15:0] i_len = '0;
    logic [3:0]  o_gnt;
    logic [3:0]  o_rvalid;
    logic [15:0] o_rdata;
    logic [19:0] o_sram_addr;
    logic [15:0] sram_dq = '0;
    logic        o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  gnt;
        logic        busy;
        logic [19:0] addr;
        logic [3:0]  rvalid;
        logic [19:0] raddr;
    } vec_t;

    vec_t vecs[$];

    sram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_len       (i_len),
        .o_gnt       (o_gnt),
        .o_rvalid    (o_rvalid),
        .o_rdata     (o_rdata),
        .o_sram_addr (o_sram_addr),
        .i_sram_dq   (sram_dq),
        .o_sram_ce_n (o_sram_ce_n),
        .o_sram_oe_n (o_sram_oe_n),
        .o_sram_we_n (o_sram_we_n),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sram_f(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A3};
    endfunction

    // Asynchronous SRAM model: data for the address of one cycle is on dq the next.
    always @(posedge clk) sram_dq <= sram_f(o_sram_addr);

    assign i_addr = {20'h3ABCD, 20'h20000, 20'hFFFFE, 20'h00100};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] req, input logic [15:0] len,
                       input logic [3:0] gnt, input logic busy, input logic [19:0] addr,
                       input logic [3:0] rvalid, input logic [19:0] raddr);
        vec_t v;
        v.rst = rst; v.req = req; v.len = len; v.gnt = gnt;
        v.busy = busy; v.addr = addr; v.rvalid = rvalid; v.raddr = raddr;
        vecs.push_back(v);
    endtask

    // Called right after a rising edge; returns right after a later rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 4'b0001;
        @(negedge clk);
        check("rst gnt", 32'(o_gnt), 32'h0);
        check("rst rvalid", 32'(o_rvalid), 32'h0);
        check("rst rdata", 32'(o_rdata), 32'h0);
        check("rst addr", 32'(o_sram_addr), 32'h0);
        check("rst strobes", 32'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n}), 32'h7);
        check("rst busy", 32'(o_busy), 32'h0);
        i_req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        // Four requesters, len 0, continuous requests: grants 0,1,2,3,0.
        add(1, 4'b1111, 16'h0000, 4'b0001, 0, 20'h00000, 4'b0000, 20'h00000);
        add(0, 4'b1111, 16'h0000, 4'b0010, 1, 20'h00100, 4'b0000, 20'h00000);
        add(0, 4'b1111, 16'h0000, 4'b0100, 1, 20'hFFFFE, 4'b0000, 20'h00000);
        add(0, 4'b1111, 16'h0000, 4'b1000, 1, 20'h20000, 4'b0001, 20'h00100);
        add(0, 4'b1111, 16'h0000, 4'b0001, 1, 20'h3ABCD, 4'b0010, 20'hFFFFE);
        add(0, 4'b0000, 16'h0000, 4'b0000, 1, 20'h00100, 4'b0100, 20'h20000);
        add(0, 4'b0000, 16'h0000, 4'b0000, 0, 20'h00000, 4'b1000, 20'h3ABCD);
        add(0, 4'b0000, 16'h0000, 4'b0000, 0, 20'h00000, 4'b0001, 20'h00100);
        add(0, 4'b0000, 16'h0000, 4'b0000, 0, 20'h00000, 4'b0000, 20'h00000);
        // Single burst from requester 0, len 3.
        add(1, 4'b0001, 16'h0003, 4'b0001, 0, 20'h00000, 4'b0000, 20'h00000);
        add(0, 4'b0000, 16'h0003, 4'b0000, 1, 20'h00100, 4'b0000, 20'h00000);
        add(0, 4'b0000, 16'h0003, 4'b0000, 1, 20'h00101, 4'b0000, 20'h00000);
        add(0, 4'b0000, 16'h0003, 4'b0000, 1, 20'h00102, 4'b0001, 20'h00100);
        add(0, 4'b0000, 16'h0003, 4'b0000, 1, 20'h00103, 4'b0001, 20'h00101);
        add(0, 4'b0000, 16'h0003, 4'b0000, 0, 20'h00000, 4'b0001, 20'h00102);
        add(0, 4'b0000, 16'h0003, 4'b0000, 0, 20'h00000, 4'b0001, 20'h00103);
        add(0, 4'b0000, 16'h0003, 4'b0000, 0, 20'h00000, 4'b0000, 20'h00000);
        // Requester 1 burst across the top of the address space.
        add(0, 4'b0010, 16'h0030, 4'b0010, 0, 20'h00000, 4'b0000, 20'h00000);
        add(0, 4'b0000, 16'h0030, 4'b0000, 1, 20'hFFFFE, 4'b0000, 20'h00000);
        add(0, 4'b0000, 16'h0030, 4'b0000, 1, 20'hFFFFF, 4'b0000, 20'h00000);
        add(0, 4'b0000, 16'h0030, 4'b0000, 1, 20'h00000, 4'b0010, 20'hFFFFE);
        add(0, 4'b0000, 16'h0030, 4'b0000, 1, 20'h00001, 4'b0010, 20'hFFFFF);
        add(0, 4'b0000, 16'h0030, 4'b0000, 0, 20'h00000, 4'b0010, 20'h00000);
        add(0, 4'b0000, 16'h0030, 4'b0000, 0, 20'h00000, 4'b0010, 20'h00001);
        add(0, 4'b0000, 16'h0030, 4'b0000, 0, 20'h00000, 4'b0000, 20'h00000);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            i_req = vecs[i].req;
            i_len = vecs[i].len;
            @(negedge clk);
            check($sformatf("row%0d gnt", i), 32'(o_gnt), 32'(vecs[i].gnt));
            check($sformatf("row%0d busy", i), 32'(o_busy), 32'(vecs[i].busy));
            check($sformatf("row%0d ce_oe_we", i),
                  32'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n}),
                  32'({~vecs[i].busy, ~vecs[i].busy, 1'b1}));
            if (vecs[i].busy)
                check($sformatf("row%0d addr", i), 32'(o_sram_addr), 32'(vecs[i].addr));
            check($sformatf("row%0d rvalid", i), 32'(o_rvalid), 32'(vecs[i].rvalid));
            if (vecs[i].rvalid != 4'b0000)
                check($sformatf("row%0d rdata", i), 32'(o_rdata), 32'(sram_f(vecs[i].raddr)));
            @(posedge clk);
            #1;
        end

        // Requester 2 arrives during a 16-beat burst; granted on the final beat, no bubble.
        i_len = 16'h000F;
        i_req = 4'b0001;
        @(negedge clk);
        check("long gnt0", 32'(o_gnt), 32'h1);
        @(posedge clk); #1;
        i_req = 4'b0000;
        for (int b = 0; b < 16; b++) begin
            if (b == 4) i_req = 4'b0100;
            @(negedge clk);
            check($sformatf("long beat%0d addr", b), 32'(o_sram_addr), 32'h100 + 32'(b));
            check($sformatf("long beat%0d gnt", b), 32'(o_gnt), (b == 15) ? 32'h4 : 32'h0);
            check($sformatf("long beat%0d busy", b), 32'(o_busy), 32'h1);
            @(posedge clk); #1;
            if (b == 15) i_req = 4'b0000;
        end
        @(negedge clk);
        check("long next busy", 32'(o_busy), 32'h1);
        check("long next addr", 32'(o_sram_addr), 32'h20000);
        repeat (4) begin
            @(posedge clk); #1;
        end

        // Requester 3 pulses for one cycle mid-burst and withdraws.
        i_len = 16'h0003;
        i_req = 4'b0001;
        @(negedge clk);
        check("wd gnt0", 32'(o_gnt), 32'h1);
        @(posedge clk); #1;
        i_req = 4'b0000;
        @(posedge clk); #1;
        i_req = 4'b1000;
        @(negedge clk);
        check("wd pulse gnt", 32'(o_gnt), 32'h0);
        @(posedge clk); #1;
        i_req = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("wd cyc%0d gnt", c), 32'(o_gnt), 32'h0);
            @(posedge clk); #1;
        end

        // Reset pulsed in beat 2 of a requester 1 burst.
        i_len = 16'h0070;
        i_req = 4'b0010;
        @(negedge clk);
        check("mr gnt1", 32'(o_gnt), 32'h2);
        @(posedge clk); #1;
        i_req = 4'b0000;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mr async strobes", 32'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n}), 32'h7);
        check("mr async busy", 32'(o_busy), 32'h0);
        check("mr async addr", 32'(o_sram_addr), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("mr cyc%0d rvalid", c), 32'(o_rvalid), 32'h0);
            @(posedge clk); #1;
        end
        i_len = 16'h0000;
        i_req = 4'b0100;
        @(negedge clk);
        check("mr new gnt", 32'(o_gnt), 32'h4);
        @(posedge clk); #1;
        i_req = 4'b0000;
        @(negedge clk);
        check("mr new addr", 32'(o_sram_addr), 32'h20000);
        check("mr new busy", 32'(o_busy), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mr new rvalid early", 32'(o_rvalid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mr new rvalid", 32'(o_rvalid), 32'h4);
        check("mr new rdata", 32'(o_rdata), 32'(sram_f(20'h20000)));
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
